// File: rtl/int_disp_recv_iq_if.sv
// ---------------------------------------------------------------------------
// int_disp_recv_iq_if
// Bundles the integer dispatch channel, the writeback wakeup bus, the flush
// line and the ALU issue port seen by the integer issue queue.
//   master : dispatch queue / writeback / ALU side (drives req, payload, tags,
//            wakeups, squash, iss_rdy)
//   slave  : issue queue side (drives disp_int_rdy, iss_*, free_cnt)
// ---------------------------------------------------------------------------
interface int_disp_recv_iq_if #(
    parameter int DISP_WID  = 4,
    parameter int DEPTH     = 16,
    parameter int PREG_W    = 7,
    parameter int PAYLOAD_W = 64,
    parameter int WB_WID    = 4
);
    localparam int FC_W = $clog2(DEPTH + 1);

    logic                           squash;
    logic [DISP_WID-1:0]            disp_int_req;
    logic [DISP_WID-1:0]            disp_int_rdy;
    logic [DISP_WID*PAYLOAD_W-1:0]  disp_int_payload;
    logic [DISP_WID*PREG_W-1:0]     disp_int_prs1;
    logic [DISP_WID*PREG_W-1:0]     disp_int_prs2;
    logic [DISP_WID-1:0]            disp_int_rs1_rdy;
    logic [DISP_WID-1:0]            disp_int_rs2_rdy;
    logic [WB_WID-1:0]              wb_vld;
    logic [WB_WID*PREG_W-1:0]       wb_prd;
    logic                           iss_vld;
    logic                           iss_rdy;
    logic [PAYLOAD_W-1:0]           iss_payload;
    logic [PREG_W-1:0]              iss_prs1;
    logic [PREG_W-1:0]              iss_prs2;
    logic [FC_W-1:0]                free_cnt;

    modport master (
        output squash, disp_int_req, disp_int_payload, disp_int_prs1, disp_int_prs2,
               disp_int_rs1_rdy, disp_int_rs2_rdy, wb_vld, wb_prd, iss_rdy,
        input  disp_int_rdy, iss_vld, iss_payload, iss_prs1, iss_prs2, free_cnt
    );

    modport slave (
        input  squash, disp_int_req, disp_int_payload, disp_int_prs1, disp_int_prs2,
               disp_int_rs1_rdy, disp_int_rs2_rdy, wb_vld, wb_prd, iss_rdy,
        output disp_int_rdy, iss_vld, iss_payload, iss_prs1, iss_prs2, free_cnt
    );
endinterface

// File: rtl/int_disp_recv_iq.sv
// ---------------------------------------------------------------------------
// int_disp_recv_iq
// Receiving end of the integer dispatch channel. Accepts up to DISP_WID uops
// per cycle into a DEPTH-entry issue queue, tracks source readiness through
// writeback wakeups and issues the lowest-index ready entry to the ALU.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - slave modport: dispatch req/rdy/payload/tags, wakeup bus, squash,
//          ALU issue valid/ready/payload/tags, registered free-entry count
// ---------------------------------------------------------------------------
module int_disp_recv_iq #(
    parameter int DISP_WID  = 4,
    parameter int DEPTH     = 16,
    parameter int PREG_W    = 7,
    parameter int PAYLOAD_W = 64,
    parameter int WB_WID    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    int_disp_recv_iq_if.slave    bus
);
    localparam int FC_W   = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LANE_W = (DISP_WID > 1) ? $clog2(DISP_WID) : 1;

    // entry storage
    logic [DEPTH-1:0]      r_vld;
    logic [DEPTH-1:0]      r_rdy1;
    logic [DEPTH-1:0]      r_rdy2;
    logic [PAYLOAD_W-1:0]  r_payload [DEPTH];
    logic [PREG_W-1:0]     r_prs1    [DEPTH];
    logic [PREG_W-1:0]     r_prs2    [DEPTH];
    logic [FC_W-1:0]       r_free_cnt;

    // per-lane views of the flattened dispatch buses
    logic [PAYLOAD_W-1:0]  w_lane_payload [DISP_WID];
    logic [PREG_W-1:0]     w_lane_prs1    [DISP_WID];
    logic [PREG_W-1:0]     w_lane_prs2    [DISP_WID];
    logic [DISP_WID-1:0]   w_lane_wake1;
    logic [DISP_WID-1:0]   w_lane_wake2;

    logic [DISP_WID-1:0]   w_rdy;
    logic [DISP_WID-1:0]   w_fire;
    logic [FC_W-1:0]       w_n_fire;

    logic [DEPTH-1:0]      w_wake1;
    logic [DEPTH-1:0]      w_wake2;
    logic [DEPTH-1:0]      w_slot_wr;
    logic [LANE_W-1:0]     w_slot_lane [DEPTH];

    logic [DEPTH-1:0]      w_cand;
    logic [IDX_W-1:0]      w_sel;
    logic                  w_iss_vld;
    logic                  w_iss_fire;

    // Ready depends only on the registered free count and squash, so the
    // master never sees a path from its own request back to rdy.
    always_comb begin
        w_rdy = '0;
        for (int i = 0; i < DISP_WID; i++) begin
            w_rdy[i] = (r_free_cnt > FC_W'(i)) & ~bus.squash;
        end
    end

    assign w_fire   = bus.disp_int_req & w_rdy;
    assign w_n_fire = FC_W'($countones(w_fire));

    always_comb begin
        w_lane_wake1 = '0;
        w_lane_wake2 = '0;
        for (int i = 0; i < DISP_WID; i++) begin
            w_lane_payload[i] = bus.disp_int_payload[i*PAYLOAD_W +: PAYLOAD_W];
            w_lane_prs1[i]    = bus.disp_int_prs1[i*PREG_W +: PREG_W];
            w_lane_prs2[i]    = bus.disp_int_prs2[i*PREG_W +: PREG_W];
            for (int w = 0; w < WB_WID; w++) begin
                if (bus.wb_vld[w] && (bus.wb_prd[w*PREG_W +: PREG_W] == w_lane_prs1[i]))
                    w_lane_wake1[i] = 1'b1;
                if (bus.wb_vld[w] && (bus.wb_prd[w*PREG_W +: PREG_W] == w_lane_prs2[i]))
                    w_lane_wake2[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int j = 0; j < DEPTH; j++) begin
            for (int w = 0; w < WB_WID; w++) begin
                if (bus.wb_vld[w] && (bus.wb_prd[w*PREG_W +: PREG_W] == r_prs1[j]))
                    w_wake1[j] = 1'b1;
                if (bus.wb_vld[w] && (bus.wb_prd[w*PREG_W +: PREG_W] == r_prs2[j]))
                    w_wake2[j] = 1'b1;
            end
        end
    end

    // The k-th free slot (ascending) is bound to lane k. A slot being issued
    // this cycle is still valid here, so it cannot be reused until next cycle.
    always_comb begin
        int k;
        k         = 0;
        w_slot_wr = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_slot_lane[j] = '0;
            if (!r_vld[j] && (k < DISP_WID)) begin
                w_slot_lane[j] = LANE_W'(k);
                w_slot_wr[j]   = w_fire[k];
                k              = k + 1;
            end
        end
    end

    // lowest-index ready entry wins
    always_comb begin
        w_cand = r_vld & r_rdy1 & r_rdy2;
        w_sel  = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (w_cand[j])
                w_sel = IDX_W'(j);
        end
    end

    assign w_iss_vld  = |w_cand;
    assign w_iss_fire = w_iss_vld & bus.iss_rdy & ~bus.squash;

    assign bus.disp_int_rdy = w_rdy;
    assign bus.iss_vld      = w_iss_vld;
    assign bus.iss_payload  = r_payload[w_sel];
    assign bus.iss_prs1     = r_prs1[w_sel];
    assign bus.iss_prs2     = r_prs2[w_sel];
    assign bus.free_cnt     = r_free_cnt;

    // Payload/tag/ready bits carry no reset: they are only looked at while
    // the matching valid bit is set, and every write sets all of them.
    always_ff @(posedge clk) begin
        if (rst || bus.squash) begin
            r_vld      <= '0;
            r_free_cnt <= FC_W'(DEPTH);
        end else begin
            r_free_cnt <= r_free_cnt - w_n_fire + FC_W'(w_iss_fire);
            for (int j = 0; j < DEPTH; j++) begin
                if (w_slot_wr[j]) begin
                    r_vld[j]     <= 1'b1;
                    r_payload[j] <= w_lane_payload[w_slot_lane[j]];
                    r_prs1[j]    <= w_lane_prs1[w_slot_lane[j]];
                    r_prs2[j]    <= w_lane_prs2[w_slot_lane[j]];
                    r_rdy1[j]    <= bus.disp_int_rs1_rdy[w_slot_lane[j]] | w_lane_wake1[w_slot_lane[j]];
                    r_rdy2[j]    <= bus.disp_int_rs2_rdy[w_slot_lane[j]] | w_lane_wake2[w_slot_lane[j]];
                end else begin
                    if (w_iss_fire && (w_sel == IDX_W'(j)))
                        r_vld[j] <= 1'b0;
                    r_rdy1[j] <= r_rdy1[j] | w_wake1[j];
                    r_rdy2[j] <= r_rdy2[j] | w_wake2[j];
                end
            end
        end
    end

    a_free_le_depth: assert property (@(posedge clk) disable iff (rst)
        r_free_cnt <= FC_W'(DEPTH));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        w_n_fire <= r_free_cnt);

    a_vld_matches_free: assert property (@(posedge clk) disable iff (rst)
        $countones(r_vld) == (DEPTH - int'(r_free_cnt)));

endmodule

// File: doc/int_disp_recv_iq.md
Name: int_disp_recv_iq

Overview:
- Slave end of the integer dispatch channel: accepts up to DISP_WID dispatched uops per cycle under per-lane req/rdy backpressure.
- Holds the uops in a DEPTH-entry issue queue and tracks source-operand readiness through writeback wakeups.
- Issues one ready uop per cycle to the integer ALU port through a valid/ready handshake.
- Sits at the entry of the int exe block; the dispatch queue is the master on the other side.

Parameters:
- DISP_WID, 4, number of dispatch lanes (equals INTDQ_DISP_WID).
- DEPTH, 16, issue-queue entries.
- PREG_W, 7, physical register tag width.
- PAYLOAD_W, 64, opaque uop payload width (opcode, imm, rob idx, prd).
- WB_WID, 4, writeback wakeup ports.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- squash  in  1  pipeline flush; drop all entries.
- disp_int_req  in  DISP_WID  per-lane dispatch request.
- disp_int_rdy  out  DISP_WID  per-lane accept.
- disp_int_payload  in  DISP_WID*PAYLOAD_W  per-lane uop payload.
- disp_int_prs1, disp_int_prs2  in  DISP_WID*PREG_W  source tags.
- disp_int_rs1_rdy, disp_int_rs2_rdy  in  DISP_WID  source already ready at rename.
- wb_vld  in  WB_WID  wakeup valid.
- wb_prd  in  WB_WID*PREG_W  woken tags.
- iss_vld  out  1  issue valid.
- iss_rdy  in  1  ALU accepts.
- iss_payload  out  PAYLOAD_W  issued payload.
- iss_prs1, iss_prs2  out  PREG_W  issued source tags.
- free_cnt  out  $clog2(DEPTH+1)  free entries (registered).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset and squash:
  - Reset clears all entry valid bits and sets free_cnt=DEPTH.
  - disp_int_rdy comes out of reset all ones (DEPTH>=DISP_WID); iss_vld=0.
  - squash has the same effect as reset on the next edge. It overrides any same-cycle dispatch or issue, which are discarded. disp_int_rdy is forced to 0 during the squash cycle.
- Ready generation:
  - disp_int_rdy[i] = (free_cnt > i) & ~squash.
  - Driven from registered state only; no combinational path from disp_int_req.
  - Lanes are prefix-ordered: the master asserts only contiguous lanes starting at 0. Lane i fires when req[i] & rdy[i].
- Allocation:
  - Fired lanes fill free slots in ascending slot index, lane 0 taking the lowest free slot.
  - Entries are written at the edge following the fire cycle.
  - free_cnt(next) = free_cnt - fired + issued_fire.
- Same-cycle issue and dispatch:
  - A slot freed by issue in cycle T is not reusable by dispatch in T.
  - It is counted in free_cnt and rdy from T+1.
- Wakeup:
  - Each cycle, every valid entry compares prs1/prs2 against all wb_prd with wb_vld set; a match sets that src ready bit at the edge.
  - A uop dispatched in the same cycle as a matching wakeup captures rsN_rdy = disp_int_rsN_rdy | match.
  - No loss window.
- Select:
  - Candidate = valid & rs1 ready & rs2 ready, all as registered state.
  - The lowest-index candidate is selected; no age ordering is guaranteed.
  - iss_vld = any candidate; iss_payload and tags come from the selected entry, muxed combinationally from registers.
  - A wakeup in cycle T makes the entry issuable in T+1 at the earliest.
  - A dispatched uop with both sources ready is issuable in T+1 after its fire cycle.
- Issue handshake:
  - iss_vld & iss_rdy clears the selected entry at the edge.
  - If iss_rdy=0 the entry stays. Selection may change next cycle if a lower-index entry becomes ready; iss_vld need not hold its payload.
- Full condition:
  - free_cnt=0 drives all rdy=0; master requests are ignored with no state change.
  - Requests on lanes with rdy=0 are never accepted.
- Assertions:
  - free_cnt never exceeds DEPTH or underflows.
  - The popcount of entry valids equals DEPTH-free_cnt.

Test Plan:
1. Reset, then dispatch 4 lanes with all srcs ready -> free_cnt 16->12 the next cycle. iss_vld=1 in the following cycle with slot 0's payload; with iss_rdy=1 the four issue over 4 consecutive cycles in slot order 0..3.
2. Fill the queue: 4 cycles of 4-lane dispatch with srcs not ready -> free_cnt=0 and disp_int_rdy=4'b0000. A 5th request is not accepted and state is unchanged.
3. free_cnt=2, master asserts req=4'b1111 -> rdy=4'b0011; only lanes 0 and 1 are written, free_cnt->0.
4. Entry with prs1=5 (not ready) and rs2 ready; wb_vld[2]=1 with wb_prd[2]=5 in cycle T -> iss_vld=1 in T+1 with iss_prs1=5.
5. Same-cycle wakeup: dispatch a uop with prs2=9 (rs2_rdy=0) while wb_prd[0]=9 is valid -> the uop issues 1 cycle after its fire.
6. Queue holding 10 entries with iss_rdy=0 and a dispatch pending; squash=1 -> next cycle free_cnt=16, iss_vld=0, and the squash-cycle dispatch is dropped.
